// File: rtl/regm_sb.sv
// Register file with per-register pending-write scoreboard; combinational reads (0 cycles), writes/reservations land on the clock edge.
// No backpressure: every write, reserve and flush is accepted in the cycle it is presented.
module regm_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NB_READ    = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NB_READ*ADDR_WIDTH-1:0] raddr_i,
    output logic [NB_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NB_READ-1:0]            rbusy_o,
    input  logic                          write_i,
    input  logic [ADDR_WIDTH-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          reserve_i,
    input  logic [ADDR_WIDTH-1:0]         rsvaddr_i,
    input  logic                          flush_i,
    output logic [ADDR_WIDTH:0]           pending_cnt_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic wr_en, rsv_en, cnt_inc, cnt_dec;

    assign wr_en  = write_i   && !((ZERO_REG != 0) && (waddr_i   == '0));
    assign rsv_en = reserve_i && !((ZERO_REG != 0) && (rsvaddr_i == '0));

    // Reserve is applied after the write clear so a newer claim on the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else begin
            if (write_i) pend_d[waddr_i]   = 1'b0;
            if (rsv_en)  pend_d[rsvaddr_i] = 1'b1;
        end
    end

    assign cnt_inc = rsv_en && !pend_q[rsvaddr_i];
    assign cnt_dec = write_i && pend_q[waddr_i] && !(rsv_en && (rsvaddr_i == waddr_i));

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) regs_q[waddr_i] <= wdata_i;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;

    genvar k;
    generate
        for (k = 0; k < NB_READ; k++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic                  zero_hit;
            logic                  byp_hit;

            assign ra       = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign zero_hit = (ZERO_REG != 0) && (ra == '0);
            assign byp_hit  = (BYPASS != 0) && write_i && (waddr_i == ra);

            assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 :
                                                         byp_hit  ? wdata_i :
                                                                    regs_q[ra];
            // Forwarded data makes the register usable now, so the reservation is hidden.
            assign rbusy_o[k] = pend_q[ra] && !zero_hit && !byp_hit;
        end
    endgenerate

endmodule

// File: tb/tb_regm_sb.sv
// Directed bench for regm_sb: default instance plus a 3-port, 16-bit, no-bypass instance.
module tb_regm_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: defaults (32-bit, 2 ports, zero reg, bypass)
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_write, a_reserve, a_flush;
    logic [4:0]  a_waddr, a_rsvaddr;
    logic [31:0] a_wdata;
    logic [5:0]  a_cnt;

    // Instance B: 16-bit, 3 ports, no bypass
    logic [14:0] b_raddr;
    logic [47:0] b_rdata;
    logic [2:0]  b_rbusy;
    logic        b_write, b_reserve, b_flush;
    logic [4:0]  b_waddr, b_rsvaddr;
    logic [15:0] b_wdata;
    logic [5:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    regm_sb dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(a_raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
        .write_i(a_write), .waddr_i(a_waddr), .wdata_i(a_wdata),
        .reserve_i(a_reserve), .rsvaddr_i(a_rsvaddr), .flush_i(a_flush),
        .pending_cnt_o(a_cnt)
    );

    regm_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NB_READ(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(b_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
        .write_i(b_write), .waddr_i(b_waddr), .wdata_i(b_wdata),
        .reserve_i(b_reserve), .rsvaddr_i(b_rsvaddr), .flush_i(b_flush),
        .pending_cnt_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        a_raddr   = '0; a_write = 1'b0; a_waddr = '0; a_wdata = '0;
        a_reserve = 1'b0; a_rsvaddr = '0; a_flush = 1'b0;
        b_raddr   = '0; b_write = 1'b0; b_waddr = '0; b_wdata = '0;
        b_reserve = 1'b0; b_rsvaddr = '0; b_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload both instances, then reset asynchronously mid-cycle
        tick();
        a_write = 1'b1; a_waddr = 5'd5; a_wdata = 32'h1111_1111;
        a_reserve = 1'b1; a_rsvaddr = 5'd3;
        b_write = 1'b1; b_waddr = 5'd2; b_wdata = 16'h5555;
        tick();
        a_write = 1'b0; a_reserve = 1'b0; b_write = 1'b0;
        a_raddr = {5'd3, 5'd5};
        #1;
        chk("preload_data", a_rdata[31:0], 64'h1111_1111);
        chk("preload_busy", a_rbusy, 64'b10);
        chk("preload_cnt", a_cnt, 64'd1);

        rst_n = 1'b0;
        #1;
        chk("rst_cnt", a_cnt, 64'd0);
        chk("rst_busy", a_rbusy, 64'd0);
        for (int i = 0; i < 32; i++) begin
            a_raddr = {5'(31 - i), 5'(i)};
            #1;
            chk("rst_rdata", a_rdata, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Write x5 with same-cycle bypass, port 1 on x6
        tick();
        a_write = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        a_raddr = {5'd6, 5'd5};
        #1;
        chk("wr_bypass", a_rdata[31:0], 64'hDEAD_BEEF);
        chk("wr_other_port", a_rdata[63:32], 64'd0);
        tick();
        a_write = 1'b0;
        #1;
        chk("wr_stored", a_rdata[31:0], 64'hDEAD_BEEF);
        chk("wr_other_stored", a_rdata[63:32], 64'd0);

        // Register 0 ignores write and reserve
        a_write = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF;
        a_reserve = 1'b1; a_rsvaddr = 5'd0;
        a_raddr = {5'd0, 5'd0};
        #1;
        chk("x0_same_rdata", a_rdata, 64'd0);
        chk("x0_same_busy", a_rbusy, 64'd0);
        tick();
        a_write = 1'b0; a_reserve = 1'b0;
        #1;
        chk("x0_rdata", a_rdata, 64'd0);
        chk("x0_busy", a_rbusy, 64'd0);
        chk("x0_cnt", a_cnt, 64'd0);

        // Reserve x3 then x7
        a_reserve = 1'b1; a_rsvaddr = 5'd3;
        tick();
        a_rsvaddr = 5'd7;
        tick();
        a_reserve = 1'b0;
        a_raddr = {5'd7, 5'd3};
        #1;
        chk("rsv_cnt", a_cnt, 64'd2);
        chk("rsv_busy", a_rbusy, 64'b11);

        // Writeback x3 clears busy in the write cycle
        a_write = 1'b1; a_waddr = 5'd3; a_wdata = 32'h12;
        #1;
        chk("clr_same_busy", a_rbusy, 64'b10);
        chk("clr_same_data", a_rdata[31:0], 64'h12);
        chk("clr_same_cnt", a_cnt, 64'd2);
        tick();
        a_write = 1'b0;
        #1;
        chk("clr_cnt", a_cnt, 64'd1);
        chk("clr_busy", a_rbusy, 64'b10);

        // Reserve and write x7 together: reserve wins
        a_reserve = 1'b1; a_rsvaddr = 5'd7;
        a_write = 1'b1; a_waddr = 5'd7; a_wdata = 32'h77;
        #1;
        chk("rw_same_busy", a_rbusy, 64'b00);
        tick();
        a_reserve = 1'b0; a_write = 1'b0;
        #1;
        chk("rw_busy", a_rbusy, 64'b10);
        chk("rw_data", a_rdata[63:32], 64'h77);
        chk("rw_cnt", a_cnt, 64'd1);

        // Pend x1, x2, x9 (x7 still pending), then flush with a competing reserve
        a_reserve = 1'b1; a_rsvaddr = 5'd1;
        tick();
        a_rsvaddr = 5'd2;
        tick();
        a_rsvaddr = 5'd9;
        tick();
        a_reserve = 1'b0;
        a_raddr = {5'd9, 5'd1};
        #1;
        chk("pre_flush_cnt", a_cnt, 64'd4);
        chk("pre_flush_busy", a_rbusy, 64'b11);
        a_flush = 1'b1; a_reserve = 1'b1; a_rsvaddr = 5'd4;
        tick();
        a_flush = 1'b0; a_reserve = 1'b0;
        a_raddr = {5'd4, 5'd9};
        #1;
        chk("flush_cnt", a_cnt, 64'd0);
        chk("flush_busy_4_9", a_rbusy, 64'd0);
        a_raddr = {5'd2, 5'd1};
        #1;
        chk("flush_busy_1_2", a_rbusy, 64'd0);
        a_raddr = {5'd7, 5'd7};
        #1;
        chk("flush_busy_7", a_rbusy, 64'd0);

        // Instance B: no bypass, three ports on x2
        b_raddr = {5'd2, 5'd2, 5'd2};
        b_reserve = 1'b1; b_rsvaddr = 5'd2;
        tick();
        b_reserve = 1'b0;
        #1;
        chk("b_rsv_busy", b_rbusy, 64'b111);
        chk("b_rsv_cnt", b_cnt, 64'd1);
        b_write = 1'b1; b_waddr = 5'd2; b_wdata = 16'hABCD;
        #1;
        chk("b_same_rdata", b_rdata, 64'd0);
        chk("b_same_busy", b_rbusy, 64'b111);
        tick();
        b_write = 1'b0;
        #1;
        chk("b_rdata", b_rdata, 64'hABCD_ABCD_ABCD);
        chk("b_busy", b_rbusy, 64'd0);
        chk("b_cnt", b_cnt, 64'd0);
        b_write = 1'b1; b_waddr = 5'd0; b_wdata = 16'hFFFF;
        tick();
        b_write = 1'b0;
        b_raddr = {5'd2, 5'd0, 5'd0};
        #1;
        chk("b_x0", b_rdata, 64'hABCD_0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regm_sb.md
# regm_sb

Parametrised register file with a per-register pending-write scoreboard, for the ECAP5-DPROC decode/writeback path. It provides NB_READ combinational read ports and one write port, with optional same-cycle write-to-read bypass and optional hardwired-zero register 0. Decode uses the scoreboard to reserve destination registers at issue and to detect read-after-write hazards. Writeback clears the reservations, and a flush clears them all.

## Interface

- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- NB_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, never becomes pending
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- raddr_i  input  NB_READ*ADDR_WIDTH  read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rdata_o  output  NB_READ*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- rbusy_o  output  NB_READ  port k's register has an outstanding reservation
- write_i  input  1  write enable
- waddr_i  input  ADDR_WIDTH  write address
- wdata_i  input  DATA_WIDTH  write data
- reserve_i  input  1  mark rsvaddr_i pending
- rsvaddr_i  input  ADDR_WIDTH  register to reserve
- flush_i  input  1  clear all pending bits
- pending_cnt_o  output  ADDR_WIDTH+1  number of registers currently pending

## Operation

- State:
  - regs[0..DEPTH-1], DATA_WIDTH each.
  - pend[0..DEPTH-1], 1 bit each.
  - pending counter, ADDR_WIDTH+1 bits.
- Reset, asynchronous on rst_ni low, independent of clk_i:
  - All regs, all pend bits and the counter are cleared to 0.
  - Outputs during and after reset: rdata_o = 0 (absent bypass), rbusy_o = 0, pending_cnt_o = 0.
- Write: if write_i=1 and the write is not suppressed, regs[waddr_i] <= wdata_i at the rising edge. A write is suppressed when ZERO_REG=1 and waddr_i=0.
- Read port k, combinational:
  - ZERO_REG=1 and raddr=0 -> 0.
  - Otherwise, BYPASS=1, write_i=1 and waddr_i=raddr -> wdata_i.
  - Otherwise -> regs[raddr].
- rbusy_o[k] = pend[raddr_k], with two exceptions:
  - Forced 0 when BYPASS=1, write_i=1 and waddr_i=raddr_k, because the data is available this cycle.
  - Always 0 for a zero-hardwired register 0.
- Scoreboard update per register r at each edge, first matching rule wins:
  1. flush_i=1 -> pend[r] <= 0. Flush overrides a same-cycle reserve.
  2. reserve_i=1 and rsvaddr_i=r, not register 0 with ZERO_REG=1 -> pend[r] <= 1. A reserve wins over a same-cycle write to the same register, since a newer instruction is claiming it.
  3. write_i=1 and waddr_i=r -> pend[r] <= 0.
  4. Otherwise hold.
- A write to a non-pending register is legal: data is written and pend stays 0.
- Reserving an already-pending register is legal: pend stays 1 and the count does not change.
- Pending counter:
  - It always equals the population count of pend. It is maintained incrementally as +1 on a 0->1 transition and -1 on a 1->0 transition, net per cycle.
  - It is 0 after a flush.
  - It never wraps, because it is sized for DEPTH.

## Timing

- Read latency: 0 cycles (combinational). Written data appears from regs on the cycle after the write edge, or in the same cycle through the bypass.
- Reservation latency: rbusy_o and pending_cnt_o reflect a reserve from the cycle after the edge.
- Clear latency: rbusy_o deasserts in the write cycle itself when BYPASS=1; otherwise it deasserts the cycle after.
- Parameter legality: reading an address ≥ DEPTH cannot occur, because addresses are exactly ADDR_WIDTH wide.
- Reset mid-operation clears all state immediately. The first edge after rst_ni rises applies normally.

## Test plan

- Reset with registers preloaded: after rst_ni low, every raddr reads 0x00000000, rbusy_o=0, pending_cnt_o=0.
- Write then read: write x5=0xDEADBEEF. In the same cycle raddr0=5 reads 0xDEADBEEF (bypass); the next cycle it reads 0xDEADBEEF from regs. Port 1 reading x6 stays 0.
- Register 0 (ZERO_REG=1): write x0=0xFFFFFFFF and reserve x0 -> x0 reads 0, rbusy=0, pending_cnt_o unchanged.
- Scoreboard:
  - Reserve x3 and x7 on consecutive cycles -> pending_cnt_o=2, and rbusy is 1 on the reading port.
  - Write x3=0x12 -> rbusy 0 in the same cycle, count 1 next cycle.
  - Reserve x7 and write x7 in the same cycle -> x7 stays pending, data updated, count still 1.
- Flush: with x1, x2 and x9 pending, assert flush_i and reserve x4 in the same cycle -> all pend bits 0 and count 0 next cycle.
- Parameter sweep: NB_READ=3, BYPASS=0, DATA_WIDTH=16. Write x2=0xABCD -> the same-cycle read returns the old value 0x0000 with rbusy as stored; the next cycle all three ports reading x2 return 0xABCD.
